// File: rtl/rv32i_types.sv
// Shared RV32I decode types: opcodes, ALU/compare ops, mux selects and the
// per-stage control word carried down the pipeline.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    localparam logic       ALU1_RS1     = 1'b0;
    localparam logic       ALU1_PC      = 1'b1;
    localparam logic [2:0] ALU2_I_IMM   = 3'b000;
    localparam logic [2:0] ALU2_U_IMM   = 3'b001;
    localparam logic [2:0] ALU2_UPPER   = 3'b010;
    localparam logic [2:0] ALU2_S_IMM   = 3'b011;
    localparam logic [2:0] ALU2_B_IMM   = 3'b100;
    localparam logic [2:0] ALU2_J_IMM   = 3'b101;
    localparam logic [2:0] ALU2_RS2     = 3'b110;
    localparam logic       CMP_RS2      = 1'b0;
    localparam logic       CMP_I_IMM    = 1'b1;
    localparam logic [2:0] WB_ALU       = 3'b000;
    localparam logic [2:0] WB_BR_EN     = 3'b001;
    localparam logic [2:0] WB_MEM       = 3'b010;
    localparam logic [2:0] WB_PC4       = 3'b011;

    typedef struct packed {
        logic [6:0]     opcode;
        alu_ops         aluop;
        branch_funct3_t cmpop;
        logic           alumux1_sel;
        logic [2:0]     alumux2_sel;
        logic           cmpmux_sel;
        logic [2:0]     wbmux_sel;
        logic           load_regfile;
        logic           dmem_read;
        logic           dmem_write;
        logic           m_op;
        logic           illegal;
        logic [4:0]     rd;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
    } rv32i_control_word;

    function automatic logic reads_rs1(input logic [6:0] op);
        return op inside {op_jalr, op_br, op_load, op_store, op_imm, op_reg};
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return op inside {op_reg, op_br, op_store};
    endfunction

endpackage

// File: rtl/ctw_decode.sv
// Combinational RV32I(M) decode of one instruction into a control word.
module ctw_decode
    import rv32i_types::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    output rv32i_control_word ctw
);

    logic is_slt;
    assign is_slt = (funct3 == 3'b010) || (funct3 == 3'b011);

    always_comb begin
        ctw       = '0;
        ctw.opcode = opcode;
        ctw.aluop  = alu_ops'(funct3);
        ctw.cmpop  = branch_funct3_t'(funct3);
        ctw.rd     = rd;
        ctw.rs1    = rs1;
        ctw.rs2    = rs2;
        case (opcode)
            op_lui: begin
                ctw.load_regfile = 1'b1;
                ctw.alumux1_sel  = ALU1_PC;
                ctw.alumux2_sel  = ALU2_UPPER;
            end
            op_auipc: begin
                ctw.aluop        = alu_add;
                ctw.load_regfile = 1'b1;
                ctw.alumux1_sel  = ALU1_PC;
                ctw.alumux2_sel  = ALU2_U_IMM;
            end
            op_jal: begin
                ctw.aluop        = alu_add;
                ctw.load_regfile = 1'b1;
                ctw.wbmux_sel    = WB_PC4;
                ctw.alumux1_sel  = ALU1_PC;
                ctw.alumux2_sel  = ALU2_J_IMM;
            end
            op_jalr: begin
                ctw.aluop        = alu_add;
                ctw.load_regfile = 1'b1;
                ctw.wbmux_sel    = WB_PC4;
            end
            op_br: begin
                // target = pc + b_imm; the condition uses cmpop = funct3 vs rs2
                ctw.aluop       = alu_add;
                ctw.alumux1_sel = ALU1_PC;
                ctw.alumux2_sel = ALU2_B_IMM;
                ctw.cmpmux_sel  = CMP_RS2;
            end
            op_load: begin
                ctw.aluop        = alu_add;
                ctw.dmem_read    = 1'b1;
                ctw.load_regfile = 1'b1;
                ctw.wbmux_sel    = WB_MEM;
            end
            op_store: begin
                ctw.aluop       = alu_add;
                ctw.dmem_write  = 1'b1;
                ctw.alumux2_sel = ALU2_S_IMM;
            end
            op_imm: begin
                ctw.load_regfile = 1'b1;
                if (funct3 == 3'b101 && funct7[5]) ctw.aluop = alu_sra;
                if (is_slt) begin
                    ctw.cmpop      = funct3[0] ? bltu : blt;
                    ctw.cmpmux_sel = CMP_I_IMM;
                    ctw.wbmux_sel  = WB_BR_EN;
                end
            end
            op_reg: begin
                if (funct7 == 7'b0000001) begin
                    if (ENABLE_M) begin
                        ctw.load_regfile = 1'b1;
                        ctw.m_op         = 1'b1;
                        ctw.alumux2_sel  = ALU2_RS2;
                    end else begin
                        ctw.illegal = 1'b1;
                    end
                end else begin
                    ctw.load_regfile = 1'b1;
                    ctw.alumux2_sel  = ALU2_RS2;
                    if (funct3 == 3'b000 && funct7[5]) ctw.aluop = alu_sub;
                    if (funct3 == 3'b101 && funct7[5]) ctw.aluop = alu_sra;
                    if (is_slt) begin
                        ctw.cmpop     = funct3[0] ? bltu : blt;
                        ctw.wbmux_sel = WB_BR_EN;
                    end
                end
            end
            default: ctw.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctw_pipeline.sv
// Control-word pipeline after decode: stall/flush/load-use handling and a
// saturating count of accepted illegal instructions.
module ctw_pipeline
    import rv32i_types::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int FLUSH_DEPTH = 1,
    parameter bit ENABLE_M    = 1'b0,
    parameter int ICNT_W      = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [6:0]                         opcode,
    input  logic [2:0]                         funct3,
    input  logic [6:0]                         funct7,
    input  logic [4:0]                         rd,
    input  logic [4:0]                         rs1,
    input  logic [4:0]                         rs2,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               stall,
    input  logic                               flush,
    output rv32i_control_word [NUM_STAGES-1:0] stage_ctw,
    output logic [NUM_STAGES-1:0]              stage_valid,
    output logic                               load_use,
    output logic [ICNT_W-1:0]                  illegal_cnt
);

    rv32i_control_word dec;
    rv32i_control_word in_ctw;
    logic              accept;
    logic              hit_rs1;
    logic              hit_rs2;

    logic [NUM_STAGES-1:0]              adv_valid;
    rv32i_control_word [NUM_STAGES-1:0] adv_ctw;

    ctw_decode #(.ENABLE_M(ENABLE_M)) u_decode (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .ctw    (dec)
    );

    // An illegal instruction reads nothing, so it never waits on a load.
    assign hit_rs1  = reads_rs1(opcode) && (rs1 == stage_ctw[0].rd);
    assign hit_rs2  = reads_rs2(opcode) && (rs2 == stage_ctw[0].rd);
    assign load_use = in_valid && stage_valid[0] && stage_ctw[0].dmem_read &&
                      (stage_ctw[0].rd != 5'd0) && !dec.illegal && (hit_rs1 || hit_rs2);

    assign in_ready = !stall && !load_use;
    assign accept   = in_valid && in_ready && !flush;
    assign in_ctw   = accept ? dec : rv32i_control_word'('0);

    assign adv_valid = {stage_valid[NUM_STAGES-2:0], accept};
    assign adv_ctw   = {stage_ctw[NUM_STAGES-2:0], in_ctw};

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
            stage_ctw   <= '0;
            illegal_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (flush && k < FLUSH_DEPTH) begin
                    stage_valid[k] <= 1'b0;
                    stage_ctw[k]   <= '0;
                end else if (!stall) begin
                    stage_valid[k] <= adv_valid[k];
                    stage_ctw[k]   <= adv_ctw[k];
                end
            end
            if (accept && dec.illegal && illegal_cnt != '1)
                illegal_cnt <= illegal_cnt + ICNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ctw_pipeline.sv
// Directed bench for ctw_pipeline: decode fields, load-use bubble, flush under
// stall, illegal-count saturation and reset during a stall.
module tb_ctw_pipeline;
    import rv32i_types::*;

    localparam int NS = 3;
    localparam int FD = 2;
    localparam int IW = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [6:0]                 opcode;
    logic [2:0]                 funct3;
    logic [6:0]                 funct7;
    logic [4:0]                 rd, rs1, rs2;
    logic                       in_valid, in_ready, stall, flush;
    rv32i_control_word [NS-1:0] stage_ctw;
    logic [NS-1:0]              stage_valid;
    logic                       load_use;
    logic [IW-1:0]              illegal_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ctw_pipeline #(
        .NUM_STAGES  (NS),
        .FLUSH_DEPTH (FD),
        .ENABLE_M    (1'b0),
        .ICNT_W      (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .stall       (stall),
        .flush       (flush),
        .stage_ctw   (stage_ctw),
        .stage_valid (stage_valid),
        .load_use    (load_use),
        .illegal_cnt (illegal_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2);
        in_valid = v;
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
    endtask

    rv32i_control_word exp_auipc, exp_lui;

    initial begin
        exp_auipc              = '0;
        exp_auipc.opcode       = 7'b0010111;
        exp_auipc.aluop        = alu_add;
        exp_auipc.cmpop        = branch_funct3_t'(3'b011);
        exp_auipc.alumux1_sel  = 1'b1;
        exp_auipc.alumux2_sel  = 3'b001;
        exp_auipc.load_regfile = 1'b1;
        exp_auipc.rd           = 5'd3;
        exp_auipc.rs1          = 5'd7;
        exp_auipc.rs2          = 5'd2;

        exp_lui              = '0;
        exp_lui.opcode       = 7'b0110111;
        exp_lui.aluop        = alu_ops'(3'b101);
        exp_lui.cmpop        = branch_funct3_t'(3'b101);
        exp_lui.alumux1_sel  = 1'b1;
        exp_lui.alumux2_sel  = 3'b010;
        exp_lui.load_regfile = 1'b1;
        exp_lui.rd           = 5'd4;
        exp_lui.rs1          = 5'd1;
        exp_lui.rs2          = 5'd9;

        // reset with an illegal instruction offered: must be ignored
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        instr(1'b1, 7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0);
        cyc();
        cyc();
        rst = 1'b0;
        in_valid = 1'b0;
        check("reset_valid", 64'(stage_valid), 64'(0));
        check("reset_ctw", 64'(stage_ctw), 64'(0));
        check("reset_icnt", 64'(illegal_cnt), 64'(0));

        // auipc then lui, no stalls
        instr(1'b1, 7'b0010111, 3'b011, 7'd0, 5'd3, 5'd7, 5'd2);
        #1;
        check("auipc_ready", 64'(in_ready), 64'(1));
        cyc();
        instr(1'b1, 7'b0110111, 3'b101, 7'd0, 5'd4, 5'd1, 5'd9);
        cyc();
        in_valid = 1'b0;
        check("two_edges_valid", 64'(stage_valid), 64'(3'b011));
        cyc();
        check("auipc_stage2", 64'(stage_ctw[2]), 64'(exp_auipc));
        check("three_edges_valid", 64'(stage_valid), 64'(3'b110));
        cyc();
        check("lui_stage2", 64'(stage_ctw[2]), 64'(exp_lui));
        check("bubble_ctw_zero", 64'(stage_ctw[0]), 64'(0));
        cyc();
        check("drained", 64'(stage_valid), 64'(0));

        // lw x5 then add x6,x5,x1
        instr(1'b1, 7'b0000011, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0);
        cyc();
        instr(1'b1, 7'b0110011, 3'b000, 7'd0, 5'd6, 5'd5, 5'd1);
        #1;
        check("lu_load_use", 64'(load_use), 64'(1));
        check("lu_ready", 64'(in_ready), 64'(0));
        cyc();
        check("lu_bubble_valid", 64'(stage_valid), 64'(3'b010));
        check("lu_bubble_ctw", 64'(stage_ctw[0]), 64'(0));
        check("lu_cleared", 64'(load_use), 64'(0));
        check("lu_ready_again", 64'(in_ready), 64'(1));
        cyc();
        in_valid = 1'b0;
        check("add_entered_valid", 64'(stage_valid), 64'(3'b101));
        check("add_entered_rd", 64'(stage_ctw[0].rd), 64'(6));
        check("add_entered_wr", 64'(stage_ctw[0].load_regfile), 64'(1));
        check("lw_in_stage2", 64'(stage_ctw[2].dmem_read), 64'(1));
        cyc(); cyc(); cyc();

        // lw x0 then use of x0
        instr(1'b1, 7'b0000011, 3'b010, 7'd0, 5'd0, 5'd2, 5'd0);
        cyc();
        instr(1'b1, 7'b0110011, 3'b000, 7'd0, 5'd6, 5'd0, 5'd1);
        #1;
        check("x0_no_load_use", 64'(load_use), 64'(0));
        check("x0_ready", 64'(in_ready), 64'(1));
        cyc();
        check("x0_back_to_back", 64'(stage_valid), 64'(3'b011));
        // lw x5 then lui whose unused rs1 field is 5
        instr(1'b1, 7'b0000011, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0);
        cyc();
        instr(1'b1, 7'b0110111, 3'b000, 7'd0, 5'd9, 5'd5, 5'd5);
        #1;
        check("lui_no_read", 64'(load_use), 64'(0));
        in_valid = 1'b0;
        cyc(); cyc(); cyc();

        // fill with addi x1, x2, x3 then flush while stalled
        for (int i = 1; i <= 3; i++) begin
            instr(1'b1, 7'b0010011, 3'b000, 7'd0, 5'(i), 5'd0, 5'd0);
            cyc();
        end
        check("filled", 64'(stage_valid), 64'(3'b111));
        stall = 1'b1; flush = 1'b1;
        #1;
        check("stall_not_ready", 64'(in_ready), 64'(0));
        cyc();
        check("flush_valid", 64'(stage_valid), 64'(3'b100));
        check("flush_s2_held", 64'(stage_ctw[2].rd), 64'(1));
        check("flush_s1_zero", 64'(stage_ctw[1]), 64'(0));
        check("flush_s0_zero", 64'(stage_ctw[0]), 64'(0));
        flush = 1'b0;
        cyc();
        check("stall_hold", 64'(stage_valid), 64'(3'b100));
        stall = 1'b0; in_valid = 1'b0;
        cyc(); cyc(); cyc();

        // mul with ENABLE_M=0 is illegal and counts
        instr(1'b1, 7'b0110011, 3'b000, 7'b0000001, 5'd7, 5'd1, 5'd2);
        cyc();
        check("mul_counted", 64'(illegal_cnt), 64'(1));
        check("mul_illegal", 64'(stage_ctw[0].illegal), 64'(1));
        check("mul_no_write", 64'(stage_ctw[0].load_regfile), 64'(0));
        // 0x7F presented 2^IW+3 times
        instr(1'b1, 7'h7F, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0);
        for (int i = 1; i <= (1 << IW) + 3; i++) begin
            cyc();
            if (i == 13) check("icnt_pre_sat", 64'(illegal_cnt), 64'(14));
            if (i == 14) check("icnt_sat", 64'(illegal_cnt), 64'(15));
        end
        check("icnt_sat_hold", 64'(illegal_cnt), 64'(15));
        check("illegal_valid", 64'(stage_valid), 64'(3'b111));

        // reset during a stall
        rst = 1'b1; stall = 1'b1;
        cyc();
        check("rst_stall_valid", 64'(stage_valid), 64'(0));
        check("rst_stall_icnt", 64'(illegal_cnt), 64'(0));
        check("rst_stall_ctw", 64'(stage_ctw), 64'(0));
        rst = 1'b0; stall = 1'b0; in_valid = 1'b0;
        cyc();
        check("post_rst_valid", 64'(stage_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
